// File: rtl/softex_tcdm_splitter.sv
// softex_tcdm_splitter
// Sits between one wide HCI TCDM master and MP independent 32-bit TCDM bank
// ports. Each narrow port is granted on its own schedule and its response is
// parked in a per-lane slot. The wide grant pulses once every port has
// granted. The wide response presents all slots together once every port
// has responded. At most one wide transaction is in flight.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   wide_req_i/gnt_o       wide request / one-cycle wide grant
//   wide_add/wen/be/data/id_i  wide request fields (wen: 1 = read)
//   wide_r_valid_o/ready_i wide response handshake
//   wide_r_data/id_o       reassembled response data and ID
//   tcdm_req_o/gnt_i       per-port request / grant
//   tcdm_add/wen/be/data/id_o  per-port request fields, lane i at [i]
//   tcdm_r_valid_i/ready_o per-port response handshake
//   tcdm_r_data_i          per-port response data, lane i at [32i+:32]
module softex_tcdm_splitter #(
   parameter int unsigned DW = 128,
   parameter int unsigned MP = DW / 32,
   parameter int unsigned IW = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               wide_req_i,
   output logic               wide_gnt_o,
   input  logic [31:0]        wide_add_i,
   input  logic               wide_wen_i,
   input  logic [DW/8-1:0]    wide_be_i,
   input  logic [DW-1:0]      wide_data_i,
   input  logic [IW-1:0]      wide_id_i,
   output logic               wide_r_valid_o,
   input  logic               wide_r_ready_i,
   output logic [DW-1:0]      wide_r_data_o,
   output logic [IW-1:0]      wide_r_id_o,
   output logic [MP-1:0]      tcdm_req_o,
   input  logic [MP-1:0]      tcdm_gnt_i,
   output logic [MP*32-1:0]   tcdm_add_o,
   output logic [MP-1:0]      tcdm_wen_o,
   output logic [MP*4-1:0]    tcdm_be_o,
   output logic [MP*32-1:0]   tcdm_data_o,
   output logic [MP*IW-1:0]   tcdm_id_o,
   output logic [MP-1:0]      tcdm_r_ready_o,
   input  logic [MP-1:0]      tcdm_r_valid_i,
   input  logic [MP*32-1:0]   tcdm_r_data_i
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RSP} state_e;

   state_e              state_q, state_d;
   logic [MP-1:0]       gmask_q, gmask_d;
   logic [MP-1:0]       rmask_q, rmask_d;
   logic [MP-1:0]       cap;
   logic                latch_en;

   logic [31:0]         add_q;
   logic                wen_q;
   logic [DW/8-1:0]     be_q;
   logic [DW-1:0]       data_q;
   logic [IW-1:0]       id_q;
   logic [DW-1:0]       slot_q;

   // Request fields: live inputs on the accepting IDLE cycle, latched copy otherwise.
   logic [31:0]         add_src;
   logic                wen_src;
   logic [DW/8-1:0]     be_src;
   logic [DW-1:0]       data_src;
   logic [IW-1:0]       id_src;

   assign latch_en = (state_q == IDLE) && wide_req_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and mask update logic
   always_comb begin
      state_d = state_q;
      gmask_d = gmask_q;
      // Responses are taken in REQ too: early-granted ports may answer first.
      cap     = tcdm_r_valid_i & ~rmask_q
                & {MP{(state_q == REQ) || (state_q == WAIT_RSP)}};
      rmask_d = rmask_q | cap;
      unique case (state_q)
         IDLE: begin
            if (wide_req_i) begin
               gmask_d = tcdm_gnt_i;
               state_d = (&tcdm_gnt_i) ? WAIT_RSP : REQ;
            end
         end
         REQ: begin
            gmask_d = gmask_q | tcdm_gnt_i;
            if (&gmask_d) state_d = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (&rmask_d) state_d = RSP;
         end
         RSP: begin
            if (wide_r_ready_i) begin
               gmask_d = '0;
               rmask_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      wide_gnt_o     = 1'b0;
      wide_r_valid_o = 1'b0;
      tcdm_req_o     = '0;
      tcdm_r_ready_o = '0;
      unique case (state_q)
         IDLE: begin
            tcdm_req_o = {MP{wide_req_i}};
            wide_gnt_o = wide_req_i & (&tcdm_gnt_i);
         end
         REQ: begin
            tcdm_req_o     = ~gmask_q;
            wide_gnt_o     = &(gmask_q | tcdm_gnt_i);
            tcdm_r_ready_o = ~rmask_q;
         end
         WAIT_RSP: begin
            tcdm_r_ready_o = ~rmask_q;
         end
         RSP: begin
            wide_r_valid_o = 1'b1;
            tcdm_r_ready_o = ~rmask_q;
         end
         default: ;
      endcase

      add_src  = latch_en ? wide_add_i  : add_q;
      wen_src  = latch_en ? wide_wen_i  : wen_q;
      be_src   = latch_en ? wide_be_i   : be_q;
      data_src = latch_en ? wide_data_i : data_q;
      id_src   = latch_en ? wide_id_i   : id_q;

      tcdm_wen_o  = {MP{wen_src}};
      tcdm_be_o   = be_src;
      tcdm_data_o = data_src;
      tcdm_add_o  = '0;
      tcdm_id_o   = '0;
      for (int unsigned i = 0; i < MP; i++) begin
         tcdm_add_o[32*i +: 32] = add_src + 32'(4 * i);
         tcdm_id_o[IW*i +: IW]  = id_src;
      end
   end

   assign wide_r_data_o = slot_q;
   assign wide_r_id_o   = id_q;

   // Masks, request latch and response slots
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gmask_q <= '0;
         rmask_q <= '0;
         add_q   <= '0;
         wen_q   <= 1'b0;
         be_q    <= '0;
         data_q  <= '0;
         id_q    <= '0;
         slot_q  <= '0;
      end else begin
         gmask_q <= gmask_d;
         rmask_q <= rmask_d;
         if (latch_en) begin
            add_q  <= wide_add_i;
            wen_q  <= wide_wen_i;
            be_q   <= wide_be_i;
            data_q <= wide_data_i;
            id_q   <= wide_id_i;
         end
         for (int unsigned i = 0; i < MP; i++) begin
            if (cap[i]) slot_q[32*i +: 32] <= tcdm_r_data_i[32*i +: 32];
         end
      end
   end

   // A response on an already-filled lane, or with nothing outstanding, is dropped.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (tcdm_r_valid_i & (rmask_q | {MP{state_q == IDLE}})) == '0)
      else $error("softex_tcdm_splitter: unexpected tcdm_r_valid_i");

endmodule

// File: tb/tb_softex_tcdm_splitter.sv
module tb_softex_tcdm_splitter;

   localparam int unsigned DW = 128;
   localparam int unsigned MP = 4;
   localparam int unsigned IW = 8;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic               wide_req_i;
   logic               wide_gnt_o;
   logic [31:0]        wide_add_i;
   logic               wide_wen_i;
   logic [DW/8-1:0]    wide_be_i;
   logic [DW-1:0]      wide_data_i;
   logic [IW-1:0]      wide_id_i;
   logic               wide_r_valid_o;
   logic               wide_r_ready_i;
   logic [DW-1:0]      wide_r_data_o;
   logic [IW-1:0]      wide_r_id_o;
   logic [MP-1:0]      tcdm_req_o;
   logic [MP-1:0]      tcdm_gnt_i;
   logic [MP*32-1:0]   tcdm_add_o;
   logic [MP-1:0]      tcdm_wen_o;
   logic [MP*4-1:0]    tcdm_be_o;
   logic [MP*32-1:0]   tcdm_data_o;
   logic [MP*IW-1:0]   tcdm_id_o;
   logic [MP-1:0]      tcdm_r_ready_o;
   logic [MP-1:0]      tcdm_r_valid_i;
   logic [MP*32-1:0]   tcdm_r_data_i;

   softex_tcdm_splitter #(.DW(DW), .MP(MP), .IW(IW)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .wide_req_i     (wide_req_i),
      .wide_gnt_o     (wide_gnt_o),
      .wide_add_i     (wide_add_i),
      .wide_wen_i     (wide_wen_i),
      .wide_be_i      (wide_be_i),
      .wide_data_i    (wide_data_i),
      .wide_id_i      (wide_id_i),
      .wide_r_valid_o (wide_r_valid_o),
      .wide_r_ready_i (wide_r_ready_i),
      .wide_r_data_o  (wide_r_data_o),
      .wide_r_id_o    (wide_r_id_o),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_be_o      (tcdm_be_o),
      .tcdm_data_o    (tcdm_data_o),
      .tcdm_id_o      (tcdm_id_o),
      .tcdm_r_ready_o (tcdm_r_ready_o),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .tcdm_r_data_i  (tcdm_r_data_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [DW-1:0] data;
      logic [IW-1:0] id;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic hold_pend = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Start of a new cycle, inputs driven away from the edge.
   task automatic nx();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sm();
      @(negedge clk_i);
   endtask

   task automatic quiet();
      wide_req_i     = 1'b0;
      wide_add_i     = '0;
      wide_wen_i     = 1'b0;
      wide_be_i      = '0;
      wide_data_i    = '0;
      wide_id_i      = '0;
      wide_r_ready_i = 1'b0;
      tcdm_gnt_i     = '0;
      tcdm_r_valid_i = '0;
      tcdm_r_data_i  = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"},     wide_gnt_o, 0);
      chk({tag, "_rvalid"},  wide_r_valid_o, 0);
      chk({tag, "_rdata"},   wide_r_data_o, 0);
      chk({tag, "_rid"},     wide_r_id_o, 0);
      chk({tag, "_req"},     tcdm_req_o, 0);
      chk({tag, "_rready"},  tcdm_r_ready_o, 0);
      chk({tag, "_add"},     tcdm_add_o, 128'h0000000C_00000008_00000004_00000000);
      chk({tag, "_wen"},     tcdm_wen_o, 0);
      chk({tag, "_be"},      tcdm_be_o, 0);
      chk({tag, "_data"},    tcdm_data_o, 0);
      chk({tag, "_id"},      tcdm_id_o, 0);
   endtask

   // Scoreboard monitor: every presented wide response is checked against the
   // queue head; the head is retired on the handshake.
   always @(negedge clk_i) begin
      if (hold_pend) chk("rvalid_hold", wide_r_valid_o, 1);
      if (rst_ni && wide_r_valid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", wide_r_valid_o, 0);
         end else begin
            chk("rsp_data", wide_r_data_o, exp_q[0].data);
            chk("rsp_id", wide_r_id_o, exp_q[0].id);
            if (wide_r_ready_i) void'(exp_q.pop_front());
         end
      end
      hold_pend = rst_ni && wide_r_valid_o && !wide_r_ready_i;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0;
      quiet();
      sm();
      chk_reset_outputs("por");
      nx();
      rst_ni = 1'b1;

      // 1: all ports grant in one cycle, read at 0x1000
      nx();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_1000; wide_wen_i = 1'b1;
      wide_be_i = '1; wide_id_i = 8'h11; tcdm_gnt_i = 4'hF;
      sm();
      chk("t1_gnt", wide_gnt_o, 1);
      chk("t1_req", tcdm_req_o, 4'hF);
      chk("t1_add", tcdm_add_o, 128'h0000100C_00001008_00001004_00001000);
      chk("t1_wen", tcdm_wen_o, 4'hF);
      chk("t1_id", tcdm_id_o, 32'h11111111);
      exp_q.push_back('{data: 128'h44444444_33333333_22222222_11111111, id: 8'h11});
      nx();
      quiet();
      tcdm_r_valid_i = 4'hF;
      tcdm_r_data_i  = 128'h44444444_33333333_22222222_11111111;
      sm();
      chk("t1_c1_gnt", wide_gnt_o, 0);
      chk("t1_c1_req", tcdm_req_o, 0);
      chk("t1_c1_rready", tcdm_r_ready_o, 4'hF);
      chk("t1_c1_rvalid", wide_r_valid_o, 0);
      nx();
      quiet();
      wide_r_ready_i = 1'b1;
      sm();
      chk("t1_c2_rvalid", wide_r_valid_o, 1);
      nx();
      quiet();
      sm();
      chk("t1_c3_rvalid", wide_r_valid_o, 0);

      // 2: staggered grants, port i at cycle i; request dropped after latching
      nx();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_2000; wide_wen_i = 1'b0;
      wide_be_i = '1; wide_data_i = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
      wide_id_i = 8'h22; tcdm_gnt_i = 4'b0001;
      sm();
      chk("t2_c0_gnt", wide_gnt_o, 0);
      chk("t2_c0_req", tcdm_req_o, 4'hF);
      nx();
      quiet();
      tcdm_gnt_i = 4'b0010; tcdm_r_valid_i = 4'b0001;
      tcdm_r_data_i = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_B0B0B0B0;
      sm();
      chk("t2_c1_gnt", wide_gnt_o, 0);
      chk("t2_c1_req", tcdm_req_o, 4'b1110);
      chk("t2_c1_add", tcdm_add_o, 128'h0000200C_00002008_00002004_00002000);
      chk("t2_c1_data", tcdm_data_o, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
      chk("t2_c1_rready", tcdm_r_ready_o, 4'hF);
      nx();
      quiet();
      tcdm_gnt_i = 4'b0100;
      sm();
      chk("t2_c2_gnt", wide_gnt_o, 0);
      chk("t2_c2_req", tcdm_req_o, 4'b1100);
      chk("t2_c2_rready", tcdm_r_ready_o, 4'b1110);
      nx();
      quiet();
      tcdm_gnt_i = 4'b1000;
      sm();
      chk("t2_c3_gnt", wide_gnt_o, 1);
      chk("t2_c3_req", tcdm_req_o, 4'b1000);
      exp_q.push_back('{data: 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, id: 8'h22});
      nx();
      quiet();
      tcdm_r_valid_i = 4'b1110;
      tcdm_r_data_i = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_DEADBEEF;
      sm();
      chk("t2_c4_gnt", wide_gnt_o, 0);
      chk("t2_c4_req", tcdm_req_o, 0);
      chk("t2_c4_rvalid", wide_r_valid_o, 0);
      nx();
      quiet();
      wide_r_ready_i = 1'b1;
      sm();
      chk("t2_c5_rvalid", wide_r_valid_o, 1);
      nx();
      quiet();

      // 3: out-of-order responses, then ready held low for 3 cycles
      nx();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_3000; wide_wen_i = 1'b1;
      wide_be_i = '1; wide_id_i = 8'h33; tcdm_gnt_i = 4'hF;
      sm();
      chk("t3_gnt", wide_gnt_o, 1);
      exp_q.push_back('{data: 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, id: 8'h33});
      nx();
      quiet();
      tcdm_r_valid_i = 4'b1000;
      tcdm_r_data_i = 128'hA3A3A3A3_55555555_55555555_55555555;
      nx();
      quiet();
      tcdm_r_data_i = '1;
      sm();
      chk("t3_c2_rready", tcdm_r_ready_o, 4'b0111);
      nx();
      quiet();
      tcdm_r_valid_i = 4'b0010;
      tcdm_r_data_i = 128'h66666666_66666666_A1A1A1A1_66666666;
      nx();
      quiet();
      tcdm_r_valid_i = 4'b0100;
      tcdm_r_data_i = 128'h77777777_A2A2A2A2_77777777_77777777;
      nx();
      quiet();
      sm();
      chk("t3_c5_rvalid", wide_r_valid_o, 0);
      nx();
      quiet();
      tcdm_r_valid_i = 4'b0001;
      tcdm_r_data_i = 128'h88888888_88888888_88888888_A0A0A0A0;
      sm();
      chk("t3_c6_rvalid", wide_r_valid_o, 0);
      for (int k = 0; k < 3; k++) begin
         nx();
         quiet();
         sm();
         chk("t3_wait_rvalid", wide_r_valid_o, 1);
         chk("t3_wait_rready", tcdm_r_ready_o, 0);
      end
      nx();
      quiet();
      wide_r_ready_i = 1'b1;
      sm();
      chk("t3_c10_rvalid", wide_r_valid_o, 1);
      nx();
      quiet();
      sm();
      chk("t3_c11_rvalid", wide_r_valid_o, 0);

      // 4: write with be=0x00F0
      nx();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_4000; wide_wen_i = 1'b0;
      wide_be_i = 16'h00F0; wide_data_i = 128'h0000_0000_0000_0000_0000_0000_CAFE_0000;
      wide_id_i = 8'h44; tcdm_gnt_i = 4'hF;
      sm();
      chk("t4_gnt", wide_gnt_o, 1);
      chk("t4_be", tcdm_be_o, 16'h00F0);
      chk("t4_wen", tcdm_wen_o, 0);
      exp_q.push_back('{data: 128'h00000004_00000003_00000002_00000001, id: 8'h44});
      nx();
      quiet();
      tcdm_r_valid_i = 4'b0111;
      tcdm_r_data_i = 128'h99999999_00000003_00000002_00000001;
      nx();
      quiet();
      tcdm_r_valid_i = 4'b1000;
      tcdm_r_data_i = 128'h00000004_99999999_99999999_99999999;
      sm();
      chk("t4_c2_rvalid", wide_r_valid_o, 0);
      nx();
      quiet();
      wide_r_ready_i = 1'b1;
      sm();
      chk("t4_c3_rvalid", wide_r_valid_o, 1);
      nx();
      quiet();

      // 5: address wrap
      nx();
      wide_req_i = 1'b1; wide_add_i = 32'hFFFF_FFF8; wide_wen_i = 1'b1;
      wide_be_i = '1; wide_id_i = 8'h55; tcdm_gnt_i = 4'hF;
      sm();
      chk("t5_add", tcdm_add_o, 128'h00000004_00000000_FFFFFFFC_FFFFFFF8);
      chk("t5_gnt", wide_gnt_o, 1);
      exp_q.push_back('{data: 128'h5D5D5D5D_5C5C5C5C_5B5B5B5B_5A5A5A5A, id: 8'h55});
      nx();
      quiet();
      tcdm_r_valid_i = 4'hF;
      tcdm_r_data_i = 128'h5D5D5D5D_5C5C5C5C_5B5B5B5B_5A5A5A5A;
      nx();
      quiet();
      wide_r_ready_i = 1'b1;
      sm();
      chk("t5_rvalid", wide_r_valid_o, 1);
      nx();
      quiet();

      // 6: reset while in REQ with gmask=0011
      nx();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_5000; wide_wen_i = 1'b1;
      wide_be_i = '1; wide_data_i = '1; wide_id_i = 8'h66; tcdm_gnt_i = 4'b0011;
      sm();
      chk("t6_c0_gnt", wide_gnt_o, 0);
      nx();
      quiet();
      tcdm_r_valid_i = 4'b0001;
      tcdm_r_data_i = 128'h12345678;
      sm();
      chk("t6_c1_req", tcdm_req_o, 4'b1100);
      #1;
      rst_ni = 1'b0;
      quiet();
      #1;
      chk_reset_outputs("t6_rst");
      nx();
      rst_ni = 1'b1;
      nx();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_6000; wide_wen_i = 1'b1;
      wide_be_i = '1; wide_id_i = 8'h67; tcdm_gnt_i = '0;
      sm();
      chk("t6_new_req", tcdm_req_o, 4'hF);
      chk("t6_new_add", tcdm_add_o, 128'h0000600C_00006008_00006004_00006000);
      chk("t6_new_gnt0", wide_gnt_o, 0);
      nx();
      quiet();
      tcdm_gnt_i = 4'hF;
      sm();
      chk("t6_new_req2", tcdm_req_o, 4'hF);
      chk("t6_new_gnt", wide_gnt_o, 1);
      exp_q.push_back('{data: 128'h6D6D6D6D_6C6C6C6C_6B6B6B6B_6A6A6A6A, id: 8'h67});
      nx();
      quiet();
      tcdm_r_valid_i = 4'hF;
      tcdm_r_data_i = 128'h6D6D6D6D_6C6C6C6C_6B6B6B6B_6A6A6A6A;
      nx();
      quiet();
      wide_r_ready_i = 1'b1;
      sm();
      chk("t6_rvalid", wide_r_valid_o, 1);
      nx();
      quiet();
      sm();
      chk("t6_idle_rvalid", wide_r_valid_o, 0);

      nx();
      sm();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/softex_tcdm_splitter.md
# softex_tcdm_splitter

Sequencing controller between the softex accelerator's wide HCI TCDM master port and MP independent 32-bit TCDM bank ports. Narrow ports are granted independently: per-port grants are tracked, the full-width grant is issued only once every port has granted, and per-port responses are reassembled into one wide response. This replaces the all-ports-in-lockstep gnt/r_valid AND-reduction in the softex wrapper, which deadlocks or drops data when banks grant or respond on different cycles.

## Interface
Parameters:
- DW, DATA_W: wide data width, multiple of 32.
- MP, DW/32: number of narrow ports.
- IW, 8: transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- wide_req_i  in  1  wide request.
- wide_gnt_o  out  1  wide grant, one-cycle pulse.
- wide_add_i  in  32  word-aligned base address.
- wide_wen_i  in  1  1 = read, 0 = write.
- wide_be_i  in  DW/8  byte enables.
- wide_data_i  in  DW  write data.
- wide_id_i  in  IW  transaction ID.
- wide_r_valid_o  out  1  wide response valid.
- wide_r_ready_i  in  1  wide response ready.
- wide_r_data_o  out  DW  reassembled read data.
- wide_r_id_o  out  IW  response ID.
- tcdm_req_o  out  MP  per-port request.
- tcdm_gnt_i  in  MP  per-port grant.
- tcdm_add_o  out  MP×32  per-port address.
- tcdm_wen_o  out  MP  per-port wen.
- tcdm_be_o  out  MP×4  per-port byte enables.
- tcdm_data_o  out  MP×32  per-port write data.
- tcdm_id_o  out  MP×IW  per-port ID.
- tcdm_r_ready_o  out  MP  per-port response ready.
- tcdm_r_valid_i  in  MP  per-port response valid.
- tcdm_r_data_i  in  MP×32  per-port response data.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, RSP. At most one wide transaction is outstanding.
- IDLE, wide_req_i=1:
  - Drive all tcdm_req_o from live inputs and latch add/wen/be/data/id.
  - gmask := tcdm_gnt_i.
  - If all ports grant this cycle: wide_gnt_o=1, go to WAIT_RSP. Otherwise go to REQ.
- REQ:
  - tcdm_req_o[i] = ~gmask[i]; fields come from the latch.
  - gmask |= tcdm_gnt_i.
  - When (gmask|tcdm_gnt_i) is all ones: wide_gnt_o=1 that cycle, go to WAIT_RSP.
  - wide_req_i is ignored after latching; a dropped request still completes.
- Narrow field mapping:
  - tcdm_add_o[i] = add + 4·i, mod 2^32; wrap is permitted.
  - tcdm_be_o[i] = be[4i+:4]; tcdm_data_o[i] = data[32i+:32]; tcdm_id_o[i] = id; tcdm_wen_o[i] = wen.
- Responses:
  - Reads and writes each return exactly one tcdm_r_valid per port.
  - tcdm_r_ready_o[i] = ~rmask[i] in every state except IDLE.
  - On tcdm_r_valid_i[i] & ~rmask[i]: capture data into slot i and set rmask[i].
  - Responses are accepted in REQ, i.e. before all grants arrive.
  - When rmask is all ones, go to RSP.
- RSP:
  - wide_r_valid_o=1, wide_r_data_o = {slot[MP-1]..slot[0]}, wide_r_id_o = latched id.
  - On wide_r_ready_i: clear gmask/rmask, go to IDLE.
  - A new wide_req_i is only serviced from IDLE, one cycle later.
- tcdm_r_valid_i[i] while rmask[i]=1, or while in IDLE, is a protocol violation: simulation assertion, data ignored.

## Timing
- Reset: state IDLE, gmask=rmask=0, all latches 0.
- All outputs are 0 during reset, except the combinational tcdm_add_o[i] = 4·i, since add=0.
- Best case, all grants at cycle t in IDLE: wide_gnt_o at t, narrow responses at t+1, wide_r_valid_o at t+2.
- Grant latency equals the slowest port's grant cycle. The wide response follows the last narrow response by one cycle.
- wide_r_valid_o holds stable until wide_r_ready_i; data and id do not change while it is high.
- Asynchronous reset mid-transaction returns the block to IDLE immediately and drops any partial grants or responses.

## Test plan
- All ports grant in the same cycle, read at add=0x1000, MP=4. Expect:
  - wide_gnt_o at cycle 0, tcdm_add_o = 0x1000/04/08/0C.
  - wide_r_valid_o at cycle 2 with the concatenated data.
- Staggered grants, port i granting at cycle i. Expect:
  - tcdm_req_o[i] drops the cycle after its grant.
  - A single wide_gnt_o pulse at cycle MP-1; no port is re-requested.
- Out-of-order responses (port 3 first, port 0 last, 5 cycles apart) with wide_r_ready_i=0 for 3 cycles. Expect:
  - Correct lane placement in wide_r_data_o.
  - wide_r_valid_o held stable until ready.
- Write with be=0x00F0 (MP=4). Expect tcdm_be_o[1]=0xF, all other lanes 0, and a wide response after 4 narrow r_valids.
- Address wrap at add=0xFFFFFFF8. Expect tcdm_add_o = 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst_ni asserted in REQ with gmask=0b0011. Expect:
  - All outputs 0 immediately.
  - After release, a new request is sent to all ports.
